// File: rtl/asi_pkg.sv
// Shared types for the AXI slave write responder: burst encodings, response codes,
// FSM states and the packed AW buffer entry.
package asi_pkg;

    localparam int ASI_IW     = 8;
    localparam int ASI_AW     = 32;
    localparam int ASI_LW     = 8;
    localparam int ASI_SW     = 3;
    localparam int ASI_BURSTW = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [ASI_IW-1:0]     id;
        logic [ASI_AW-1:0]     addr;
        logic [ASI_LW-1:0]     len;
        logic [ASI_SW-1:0]     size;
        logic [ASI_BURSTW-1:0] burst;
    } aw_entry_t;

endpackage

// File: rtl/asi_fifo.sv
// Generic synchronous FIFO with a combinational head read.
// Latency: pushed data is visible at dout the cycle after the push; full blocks writes.
module asi_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(D);

    logic [W-1:0] mem_q [D];
    logic [PW:0]  wr_q, wr_d, rd_q, rd_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign dout  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push && !full) wr_d = wr_q + (PW+1)'(1);
        if (pop && !empty) rd_d = rd_q + (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[PW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/asi_w.sv
// AXI4 write-path slave: buffers AW, walks FIXED/INCR/WRAP beat addresses onto a user port, one B per burst.
// Latency: AW to first WREADY 2 cycles; BVALID the cycle after the last beat. WREADY follows usr_wready.
// WRAP support is compiled only with ASI_WRAP_EN; otherwise WRAP bursts are consumed and answered SLVERR.
module asi_w import asi_pkg::*; #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = ASI_AW,
    parameter int AXI_IW     = ASI_IW,
    parameter int AXI_LW     = ASI_LW,
    parameter int AXI_SW     = ASI_SW,
    parameter int AXI_BURSTW = ASI_BURSTW,
    parameter int AXI_BRESPW = 2,
    parameter int ASI_AD     = 4,
    parameter int AXI_WSTRBW = AXI_DW/8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [AXI_IW-1:0]     AWID,
    input  logic [AXI_AW-1:0]     AWADDR,
    input  logic [AXI_LW-1:0]     AWLEN,
    input  logic [AXI_SW-1:0]     AWSIZE,
    input  logic [AXI_BURSTW-1:0] AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [AXI_DW-1:0]     WDATA,
    input  logic [AXI_WSTRBW-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [AXI_IW-1:0]     BID,
    output logic [AXI_BRESPW-1:0] BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  usr_we,
    output logic [AXI_AW-1:0]     usr_waddr,
    output logic [AXI_DW-1:0]     usr_wdata,
    output logic [AXI_WSTRBW-1:0] usr_wstrb,
    input  logic                  usr_wready
);

    localparam logic [ASI_SW-1:0] MAX_SIZE = ASI_SW'($clog2(AXI_WSTRBW));

    state_t              state_q, state_d;
    logic [AXI_IW-1:0]   id_q, id_d;
    logic [AXI_AW-1:0]   addr_q, addr_d, step_q, step_d, nxt_addr;
    logic [AXI_LW-1:0]   len_q, len_d, beat_q, beat_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d, cfg_err_q, cfg_err_d, init_q, init_d;
`ifdef ASI_WRAP_EN
    logic [AXI_AW-1:0]   mask_q, mask_d, h_mask;
`endif

    aw_entry_t           push_ent, head;
    logic                fifo_full, fifo_empty, pop, w_hs, last_beat;
    logic [AXI_AW-1:0]   h_addr, h_step, h_aligned;
    logic [AXI_LW-1:0]   h_len;
    logic                h_wrap_bad, h_cfg_err;

    assign push_ent = '{id: ASI_IW'(AWID), addr: ASI_AW'(AWADDR), len: ASI_LW'(AWLEN),
                        size: ASI_SW'(AWSIZE), burst: ASI_BURSTW'(AWBURST)};

    asi_fifo #(.W($bits(aw_entry_t)), .D(ASI_AD)) u_aw_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (AWVALID & AWREADY),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode of the buffer head, latched when the burst starts
    assign h_addr    = AXI_AW'(head.addr);
    assign h_len     = AXI_LW'(head.len);
    assign h_step    = AXI_AW'(1) << head.size;
    assign h_aligned = h_addr & ~(h_step - AXI_AW'(1));
`ifdef ASI_WRAP_EN
    assign h_wrap_bad = (head.burst == BURST_WRAP) &&
                        !(h_len == AXI_LW'(1) || h_len == AXI_LW'(3) ||
                          h_len == AXI_LW'(7) || h_len == AXI_LW'(15));
    assign h_mask     = ((AXI_AW'(h_len) + AXI_AW'(1)) << head.size) - AXI_AW'(1);
`else
    assign h_wrap_bad = (head.burst == BURST_WRAP);
`endif
    assign h_cfg_err = (head.size > MAX_SIZE) || (head.burst == 2'b11) || h_wrap_bad;

    always_comb begin
        nxt_addr = addr_q;
        case (burst_q)
            BURST_INCR: nxt_addr = addr_q + step_q;
`ifdef ASI_WRAP_EN
            // Wrap boundary is T-aligned, so wrapping is just keeping the in-window offset
            BURST_WRAP: nxt_addr = (addr_q & ~mask_q) | ((addr_q + step_q) & mask_q);
`endif
            default:    nxt_addr = addr_q;
        endcase
    end

    assign last_beat = (beat_q == len_q);
    assign w_hs      = (state_q == ST_DATA) && WVALID && usr_wready;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        step_d    = step_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_d     = err_q;
        cfg_err_d = cfg_err_q;
        init_d    = 1'b1;
        pop       = 1'b0;
`ifdef ASI_WRAP_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    id_d      = AXI_IW'(head.id);
                    addr_d    = h_aligned;
                    step_d    = h_step;
                    len_d     = h_len;
                    burst_d   = head.burst;
                    beat_d    = '0;
                    err_d     = h_cfg_err;
                    cfg_err_d = h_cfg_err;
`ifdef ASI_WRAP_EN
                    mask_d    = h_mask;
`endif
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (WLAST != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + AXI_LW'(1);
                        addr_d = nxt_addr;
                    end
                end
            end
            ST_RESP: begin
                if (BREADY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            step_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            init_q    <= 1'b0;
`ifdef ASI_WRAP_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            step_q    <= step_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_err_d;
            init_q    <= init_d;
`ifdef ASI_WRAP_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign AWREADY   = init_q && !fifo_full;
    assign WREADY    = (state_q == ST_DATA) && usr_wready;
    assign BVALID    = (state_q == ST_RESP);
    assign BID       = id_q;
    assign BRESP     = (BVALID && err_q) ? AXI_BRESPW'(RESP_SLVERR) : AXI_BRESPW'(RESP_OKAY);
    assign usr_we    = w_hs && !cfg_err_q;
    assign usr_waddr = addr_q;
    assign usr_wdata = WDATA;
    assign usr_wstrb = WSTRB;

endmodule

// File: tb/tb_asi_w.sv
// Directed bench for asi_w: burst address walks, error bursts, AW buffering, stalls and mid-burst reset.
module tb_asi_w;
    import asi_pkg::*;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [7:0]   AWID;
    logic [31:0]  AWADDR;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE;
    logic [1:0]   AWBURST;
    logic         AWVALID, AWREADY;
    logic [127:0] WDATA;
    logic [15:0]  WSTRB;
    logic         WLAST, WVALID, WREADY;
    logic [7:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID, BREADY;
    logic         usr_we;
    logic [31:0]  usr_waddr;
    logic [127:0] usr_wdata;
    logic [15:0]  usr_wstrb;
    logic         usr_wready;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [31:0] exp_addr [16];

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) if (usr_we) wr_cnt <= wr_cnt + 1;

    asi_w dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
        .usr_wready(usr_wready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        #1;
        while (!AWREADY && t < 50) begin
            @(negedge ACLK);
            #1;
            t++;
        end
        chk("aw_accept", AWREADY, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    // last_at < 0: WLAST on the true final beat; otherwise WLAST only on beat last_at
    task automatic send_beats(input int nb, input logic exp_we, input int last_at, input bit toggle);
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            @(negedge ACLK);
            WVALID = 1'b1;
            WDATA  = {4{b}};
            WSTRB  = '1;
            WLAST  = (last_at >= 0) ? (b == last_at) : (b == nb - 1);
            if (toggle) usr_wready = 1'b0;
            #1;
            while (!WREADY && t < 50) begin
                chk("we_while_stalled", usr_we, 1'b0);
                @(negedge ACLK);
                usr_wready = 1'b1;
                #1;
                t++;
            end
            chk("wready_seen", WREADY, 1'b1);
            chk("usr_we", usr_we, exp_we);
            if (exp_we) begin
                chk("usr_waddr", usr_waddr, exp_addr[b]);
                chk("usr_wdata", usr_wdata, {4{b}});
            end
        end
        @(negedge ACLK);
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic expect_b(input logic [7:0] id, input logic [1:0] resp, input int hold);
        int t = 0;
        while (!BVALID && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        chk("bvalid", BVALID, 1'b1);
        chk("bid", BID, id);
        chk("bresp", BRESP, resp);
        for (int h = 0; h < hold; h++) begin
            @(negedge ACLK);
            chk("bvalid_hold", BVALID, 1'b1);
            chk("bid_hold", BID, id);
            chk("bresp_hold", BRESP, resp);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("bvalid_drop", BVALID, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; usr_wready = 1'b1;

        // Reset values
        repeat (2) @(negedge ACLK);
        chk("rst_awready", AWREADY, 1'b0);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_bid", BID, 8'h00);
        chk("rst_bresp", BRESP, 2'b00);
        chk("rst_usr_we", usr_we, 1'b0);
        chk("rst_usr_waddr", usr_waddr, 32'h0);
        ARESETn = 1'b1;
        #1;
        chk("awready_at_release", AWREADY, 1'b0);
        @(negedge ACLK);
        chk("awready_after_release", AWREADY, 1'b1);

        // INCR, unaligned start, with AW->WREADY and last-beat->BVALID latency
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1010;
        exp_addr[2] = 32'h1020; exp_addr[3] = 32'h1030;
        do_aw(8'h5A, 32'h1004, 8'd3, 3'd4, BURST_INCR);
        chk("wready_lat_1", WREADY, 1'b0);
        @(negedge ACLK);
        chk("wready_lat_2", WREADY, 1'b1);
        send_beats(4, 1'b1, -1, 1'b0);
        chk("b_latency", BVALID, 1'b1);
        expect_b(8'h5A, RESP_OKAY, 0);

        // WRAP: 0x38 LEN3 SIZE4 wraps inside the 64-byte window at 0x00
        exp_addr[0] = 32'h30; exp_addr[1] = 32'h00;
        exp_addr[2] = 32'h10; exp_addr[3] = 32'h20;
        do_aw(8'h11, 32'h38, 8'd3, 3'd4, BURST_WRAP);
`ifdef ASI_WRAP_EN
        send_beats(4, 1'b1, -1, 1'b0);
        expect_b(8'h11, RESP_OKAY, 0);
`else
        send_beats(4, 1'b0, -1, 1'b0);
        expect_b(8'h11, RESP_SLVERR, 0);
`endif

        // AW buffering: hold burst 9 in RESP, fill the buffer with IDs 1-4
        exp_addr[0] = 32'h0;
        do_aw(8'h09, 32'h0, 8'd0, 3'd2, BURST_INCR);
        send_beats(1, 1'b1, -1, 1'b0);
        for (int i = 1; i <= 4; i++) do_aw(8'(i), 32'(i) << 8, 8'd0, 3'd2, BURST_INCR);
        chk("awready_full", AWREADY, 1'b0);
        expect_b(8'h09, RESP_OKAY, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_addr[0] = 32'(i) << 8;
            send_beats(1, 1'b1, -1, 1'b0);
            expect_b(8'(i), RESP_OKAY, 0);
        end

        // WLAST mismatch: beats still written, response SLVERR
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h210;
        do_aw(8'h21, 32'h200, 8'd1, 3'd4, BURST_INCR);
        send_beats(2, 1'b1, 0, 1'b0);
        expect_b(8'h21, RESP_SLVERR, 0);

        // Oversized beat: consumed silently, SLVERR
        wr_base = wr_cnt;
        do_aw(8'h22, 32'h0, 8'd1, 3'd5, BURST_INCR);
        send_beats(2, 1'b0, -1, 1'b0);
        expect_b(8'h22, RESP_SLVERR, 0);
        chk("size_err_writes", 64'(wr_cnt - wr_base), 64'd0);

        // usr_wready toggling over LEN7 with B held 5 cycles
        for (int i = 0; i < 8; i++) exp_addr[i] = 32'h2000 + 32'(i) * 32'h10;
        wr_base = wr_cnt;
        do_aw(8'h33, 32'h2000, 8'd7, 3'd4, BURST_INCR);
        send_beats(8, 1'b1, -1, 1'b1);
        chk("toggle_write_count", 64'(wr_cnt - wr_base), 64'd8);
        expect_b(8'h33, RESP_OKAY, 5);
        usr_wready = 1'b1;

        // Reset during beat 2 of LEN7: everything clears, no B, then a clean burst
        exp_addr[0] = 32'h400; exp_addr[1] = 32'h410;
        do_aw(8'h07, 32'h400, 8'd7, 3'd4, BURST_INCR);
        send_beats(2, 1'b1, -1, 1'b0);
        @(negedge ACLK);
        WVALID = 1'b1;
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_wready", WREADY, 1'b0);
        chk("mid_rst_usr_we", usr_we, 1'b0);
        chk("mid_rst_bvalid", BVALID, 1'b0);
        chk("mid_rst_bid", BID, 8'h00);
        chk("mid_rst_usr_waddr", usr_waddr, 32'h0);
        chk("mid_rst_awready", AWREADY, 1'b0);
        WVALID = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("no_b_after_rst", BVALID, 1'b0);
        exp_addr[0] = 32'h84; exp_addr[1] = 32'h88;
        do_aw(8'h03, 32'h84, 8'd1, 3'd2, BURST_INCR);
        send_beats(2, 1'b1, -1, 1'b0);
        expect_b(8'h03, RESP_OKAY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
